// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : raster timing (pixel enable, x/y counters, syncs, blanking)
// Rev 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] x_coord,
  output logic [9:0] y_coord,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_params
      $error("vga_timing_gen: illegal geometry or CLK_DIV");
    end
  endgenerate

  localparam logic [3:0]  DIV_MAX  = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0] div_q, div_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       hs_q, hs_d, vs_q, vs_d, von_q, von_d;
  logic       tick_q, tick_d, ls_q, ls_d, fs_q, fs_d;
  logic       w_adv;
  logic [10:0] w_x_ext, w_y_ext;

  assign w_adv   = (div_q == DIV_MAX);
  assign w_x_ext = {1'b0, x_d};
  assign w_y_ext = {1'b0, y_d};

  // Syncs and blanking decode the next-state coordinates so they line up
  // with x_coord/y_coord on the same cycle.
  always_comb begin
    div_d = w_adv ? 4'd0 : div_q + 4'd1;
    x_d   = x_q;
    y_d   = y_q;
    if (w_adv) begin
      if (x_q == H_MAX) begin
        x_d = 10'd0;
        y_d = (y_q == V_MAX) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    hs_d   = !(w_x_ext >= HS_START && w_x_ext < HS_END);
    vs_d   = !(w_y_ext >= VS_START && w_y_ext < VS_END);
    von_d  = (w_x_ext < H_VIS) && (w_y_ext < V_VIS);
    tick_d = w_adv;
    ls_d   = w_adv && (x_d == 10'd0);
    fs_d   = w_adv && (x_d == 10'd0) && (y_d == 10'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= 4'd0;
      x_q    <= H_MAX;
      y_q    <= V_MAX;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      von_q  <= 1'b0;
      tick_q <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      x_q    <= x_d;
      y_q    <= y_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      von_q  <= von_d;
      tick_q <= tick_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  assign pix_tick    = tick_q;
  assign x_coord     = x_q;
  assign y_coord     = y_q;
  assign video_on    = von_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_vga_timing_gen : scoreboard bench over three geometries / dividers
// Rev 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  localparam int ND = 3;
  localparam int CD [ND] = '{2, 1, 2};
  localparam int HA [ND] = '{16, 16, 640};
  localparam int HF [ND] = '{2, 2, 16};
  localparam int HS [ND] = '{4, 4, 96};
  localparam int HB [ND] = '{3, 3, 48};
  localparam int VA [ND] = '{8, 8, 480};
  localparam int VF [ND] = '{2, 2, 10};
  localparam int VS [ND] = '{2, 2, 2};
  localparam int VB [ND] = '{3, 3, 33};

  logic          clk = 1'b0;
  logic [ND-1:0] rst_r = '1;
  logic          tick_o [ND];
  logic [9:0]    x_o    [ND];
  logic [9:0]    y_o    [ND];
  logic          von_o  [ND];
  logic          hs_o   [ND];
  logic          vs_o   [ND];
  logic          fs_o   [ND];
  logic          ls_o   [ND];

  always #5 clk = ~clk;

  generate
    for (genvar i = 0; i < ND; i++) begin : g_dut
      vga_timing_gen #(
        .CLK_DIV(CD[i]), .H_ACTIVE(HA[i]), .H_FP(HF[i]), .H_SYNC(HS[i]), .H_BP(HB[i]),
        .V_ACTIVE(VA[i]), .V_FP(VF[i]), .V_SYNC(VS[i]), .V_BP(VB[i])
      ) u_dut (
        .clk(clk), .rst(rst_r[i]), .pix_tick(tick_o[i]), .x_coord(x_o[i]), .y_coord(y_o[i]),
        .video_on(von_o[i]), .hsync(hs_o[i]), .vsync(vs_o[i]),
        .frame_start(fs_o[i]), .line_start(ls_o[i])
      );
    end
  endgenerate

  typedef struct {
    int         d;
    logic       tick, ls, fs, von, hs, vs;
    logic [9:0] x, y;
  } exp_t;

  exp_t sbq [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_div [ND], m_x [ND], m_y [ND];
  bit   m_tick [ND], m_ls [ND], m_fs [ND];
  int   run_h [ND], run_v [ND], last_ls [ND], last_fs [ND];

  function automatic int ht(int d); return HA[d] + HF[d] + HS[d] + HB[d]; endfunction
  function automatic int vt(int d); return VA[d] + VF[d] + VS[d] + VB[d]; endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: state after the coming clock edge, given the rst level then.
  task automatic model_push(int d);
    exp_t e;
    bit   adv;
    if (rst_r[d]) begin
      m_div[d] = 0; m_x[d] = ht(d) - 1; m_y[d] = vt(d) - 1;
      m_tick[d] = 0; m_ls[d] = 0; m_fs[d] = 0;
    end else begin
      adv = (m_div[d] == CD[d] - 1);
      m_div[d] = adv ? 0 : m_div[d] + 1;
      m_tick[d] = adv; m_ls[d] = 0; m_fs[d] = 0;
      if (adv) begin
        if (m_x[d] == ht(d) - 1) begin
          m_x[d] = 0;
          m_y[d] = (m_y[d] == vt(d) - 1) ? 0 : m_y[d] + 1;
        end else m_x[d] = m_x[d] + 1;
        m_ls[d] = (m_x[d] == 0);
        m_fs[d] = (m_x[d] == 0) && (m_y[d] == 0);
      end
    end
    e.d = d; e.tick = m_tick[d]; e.ls = m_ls[d]; e.fs = m_fs[d];
    e.x = 10'(m_x[d]); e.y = 10'(m_y[d]);
    e.hs  = !(m_x[d] >= HA[d] + HF[d] && m_x[d] < HA[d] + HF[d] + HS[d]);
    e.vs  = !(m_y[d] >= VA[d] + VF[d] && m_y[d] < VA[d] + VF[d] + VS[d]);
    e.von = (m_x[d] < HA[d]) && (m_y[d] < VA[d]);
    sbq.push_back(e);
  endtask

  task automatic measure(int d);
    if (rst_r[d]) begin
      run_h[d] = 0; run_v[d] = 0; last_ls[d] = -1; last_fs[d] = -1;
    end else begin
      if (!hs_o[d]) run_h[d]++;
      else if (run_h[d] > 0) begin chk($sformatf("d%0d_hs_width", d), run_h[d], HS[d] * CD[d]); run_h[d] = 0; end
      if (!vs_o[d]) run_v[d]++;
      else if (run_v[d] > 0) begin chk($sformatf("d%0d_vs_width", d), run_v[d], VS[d] * ht(d) * CD[d]); run_v[d] = 0; end
      if (ls_o[d]) begin
        if (last_ls[d] >= 0) chk($sformatf("d%0d_line_period", d), cyc - last_ls[d], ht(d) * CD[d]);
        last_ls[d] = cyc;
      end
      if (fs_o[d]) begin
        if (last_fs[d] >= 0) chk($sformatf("d%0d_frame_period", d), cyc - last_fs[d], ht(d) * vt(d) * CD[d]);
        last_fs[d] = cyc;
      end
    end
  endtask

  // One clock: predict, let the edge happen, then pop and compare every DUT.
  task automatic cycle();
    exp_t e;
    for (int d = 0; d < ND; d++) model_push(d);
    @(posedge clk);
    #1;
    cyc++;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk($sformatf("d%0d_x", e.d), x_o[e.d], e.x);
      chk($sformatf("d%0d_y", e.d), y_o[e.d], e.y);
      chk($sformatf("d%0d_tick", e.d), tick_o[e.d], e.tick);
      chk($sformatf("d%0d_line_start", e.d), ls_o[e.d], e.ls);
      chk($sformatf("d%0d_frame_start", e.d), fs_o[e.d], e.fs);
      chk($sformatf("d%0d_hsync", e.d), hs_o[e.d], e.hs);
      chk($sformatf("d%0d_vsync", e.d), vs_o[e.d], e.vs);
      chk($sformatf("d%0d_video_on", e.d), von_o[e.d], e.von);
      measure(e.d);
    end
  endtask

  initial begin
    int  n;
    for (int d = 0; d < ND; d++) begin
      m_div[d] = 0; m_x[d] = ht(d) - 1; m_y[d] = vt(d) - 1;
      run_h[d] = 0; run_v[d] = 0; last_ls[d] = -1; last_fs[d] = -1;
    end

    // Reset held: reset values on every DUT.
    repeat (3) cycle();

    // Release and run: two+ frames on the small geometries, two lines at defaults.
    rst_r = '0;
    repeat (3300) cycle();

    // Walk DUT 0 into both sync pulses, then hit it with an unaligned reset.
    n = 0;
    while (!(m_x[0] == 20 && m_y[0] == 11) && n < 800) begin
      cycle();
      n++;
    end
    chk("d0_reach_sync_target", (n < 800), 1'b1);
    #2;
    rst_r[0] = 1'b1;
    #1;
    chk("d0_async_hsync", hs_o[0], 1'b1);
    chk("d0_async_vsync", vs_o[0], 1'b1);
    chk("d0_async_x", x_o[0], 10'(ht(0) - 1));
    chk("d0_async_y", y_o[0], 10'(vt(0) - 1));
    chk("d0_async_video_on", von_o[0], 1'b0);
    chk("d0_async_tick", tick_o[0], 1'b0);
    repeat (2) cycle();
    rst_r[0] = 1'b0;
    repeat (1600) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the 640x480@60 Hz VGA output path.
- Sits directly upstream of the background/sprite pixel stages.
- Divides the system clock into a pixel-rate enable and runs the horizontal and vertical counters.
- Drives hsync, vsync, video_on and the pixel coordinates that the colour stages decode.

Parameters:
- CLK_DIV, 2, system clocks per pixel (50 MHz -> 25 MHz); legal range 1..16.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- pix_tick  output  1  one-clk pulse; the coordinates advance on this clk edge.
- x_coord  output  10  horizontal count, 0..H_TOTAL-1.
- y_coord  output  10  vertical count, 0..V_TOTAL-1.
- video_on  output  1  high when x_coord < H_ACTIVE and y_coord < V_ACTIVE.
- hsync  output  1  active-low horizontal sync.
- vsync  output  1  active-low vertical sync.
- frame_start  output  1  one-clk pulse on entry to (0,0).
- line_start  output  1  one-clk pulse on entry to x=0 of any line.

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Both totals must be <= 1024; elaboration fails otherwise.
- Reset is asynchronous and active-high; all state is cleared immediately on rst assertion.
- Reset values:
  - div_cnt = 0
  - x_coord = H_TOTAL-1 (799), y_coord = V_TOTAL-1 (524)
  - hsync = 1, vsync = 1, video_on = 0
  - pix_tick = 0, frame_start = 0, line_start = 0
- Reset pre-positions the raster on the last pixel of the frame, so the first advance after reset lands on (0,0).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - Internal advance enable is high when div_cnt == CLK_DIV-1.
  - With CLK_DIV=1, advance is high every clk.
  - First advance occurs CLK_DIV clks after rst deassertion.
- Counters, on each advance:
  - x_coord increments; at H_TOTAL-1 it wraps to 0 and y_coord increments.
  - y_coord wraps from V_TOTAL-1 to 0 when x_coord also wraps.
  - Counters hold between advances.
- Sync and blank decode:
  - hsync, vsync and video_on are registered, computed from the next-state counter values.
  - They are therefore always consistent with the x_coord/y_coord present on the same cycle; there is no pipeline skew for downstream stages.
  - hsync = 0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, i.e. x in 656..751.
  - vsync = 0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, i.e. y in 490..491.
  - vsync changes only on an advance where x wraps to 0.
- Pulses:
  - pix_tick is high for exactly the one clk following each advance edge, i.e. the first cycle the new coordinate is valid.
  - line_start is high in that same clk when the new x = 0.
  - frame_start is high in that same clk when the new x = 0 and y = 0.
  - All pulses are exactly one clk wide, including when CLK_DIV=1 (then pix_tick is continuously high).
- Reset mid-frame: outputs go to reset values asynchronously; the frame restarts cleanly at (0,0) after release, with no partial sync pulse extension beyond reset.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV clks = 840000 at the defaults.

Test Plan:
- Hold rst, then release -> reset values as listed while rst is high; CLK_DIV clks after release: x=0, y=0, video_on=1, frame_start=1, line_start=1, pix_tick=1, each pulse for one clk only.
- Run one line at the defaults -> hsync low for exactly 96*2 = 192 clks, starting at x=656; video_on low from x=640 through x=799; line_start period = 1600 clks.
- Run one full frame -> vsync low only for y=490..491 (1600*2 = 3200 clks); frame_start pulses exactly 840000 clks apart; y never exceeds 524 and x never exceeds 799.
- CLK_DIV=1 -> coordinates advance every clk; pix_tick stuck high; frame_start period = 420000 clks; hsync width = 96 clks.
- Assert rst asynchronously (not clock-aligned) at x=700, y=491, i.e. inside both sync pulses -> hsync and vsync return to 1 within that cycle; after release, timing matches the first scenario.
- Every cycle, checker compares hsync/vsync/video_on against a decode of the same-cycle x_coord/y_coord -> zero mismatches over 2 full frames.
